// File: rtl/ysyx_22041752_icache_cmp.sv
// I-cache compare/refill stage: tag/valid/LRU arrays, hit delivery to IF,
// and a single-line refill from memory into the victim SRAM bank on a miss.
module ysyx_22041752_icache_cmp #(
  parameter int PC_WD     = 32,
  parameter int INDEX_WD  = 7,
  parameter int OFFSET_WD = 4,
  parameter int LINE_WD   = 128,
  parameter int MEM_WD    = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rs_to_cs_valid,
  input  logic [PC_WD+3:0]      rs_to_cs_bus,
  output logic                  cmp_allowin,
  input  logic [LINE_WD-1:0]    sram_rdata0,
  input  logic [LINE_WD-1:0]    sram_rdata1,
  input  logic [LINE_WD-1:0]    sram_rdata2,
  input  logic [LINE_WD-1:0]    sram_rdata3,
  output logic [3:0]            sram_wen,
  output logic [INDEX_WD-2:0]   sram_waddr,
  output logic [LINE_WD-1:0]    sram_wdata,
  output logic                  mem_rd_req,
  output logic [PC_WD-1:0]      mem_rd_addr,
  input  logic                  mem_rd_rdy,
  input  logic                  mem_ret_valid,
  input  logic                  mem_ret_last,
  input  logic [MEM_WD-1:0]     mem_ret_data,
  input  logic                  fs_allowin,
  input  logic                  flush,
  output logic                  cs_to_fs_valid,
  output logic [31:0]           cs_inst,
  output logic [PC_WD-1:0]      cs_pc
);

  localparam int TAG_WD  = PC_WD - INDEX_WD - OFFSET_WD;
  localparam int SETS    = 1 << INDEX_WD;
  localparam int WORD_WD = OFFSET_WD - 2;
  localparam int NWORDS  = LINE_WD / 32;
  localparam int NBEATS  = LINE_WD / MEM_WD;

  typedef enum logic [1:0] {LOOKUP, MISS, REFILL, WRITE} state_e;

  state_e                           state_q, state_d;
  logic                             cs_valid_q, cs_valid_d;
  logic                             first_q, first_d;
  logic                             hit_q, hit_d;
  logic                             cancel_q, cancel_d;
  logic                             beat_q, beat_d;
  logic [PC_WD-1:0]                 addr_q, addr_d;
  logic [3:0]                       bank_en_q, bank_en_d;
  logic [31:0]                      hold_q, hold_d;
  logic [NBEATS-1:0][MEM_WD-1:0]    line_buf_q, line_buf_d;
  logic [SETS-1:0]                  valid0_q, valid0_d, valid1_q, valid1_d;
  logic [SETS-1:0]                  lru_q, lru_d;
  logic [TAG_WD-1:0]                tag0_q [SETS];
  logic [TAG_WD-1:0]                tag0_d [SETS];
  logic [TAG_WD-1:0]                tag1_q [SETS];
  logic [TAG_WD-1:0]                tag1_d [SETS];

  logic [INDEX_WD-1:0]              idx;
  logic [TAG_WD-1:0]                tag_in;
  logic [WORD_WD-1:0]               word;
  logic [LINE_WD-1:0]               bank_data [4];
  logic [NWORDS-1:0][31:0]          hit_words;
  logic [NWORDS-1:0][31:0]          buf_words;
  logic                             hit0, hit1, hit_now, hit_way, cur_hit, victim;
  logic                             accept;

  assign idx    = addr_q[OFFSET_WD +: INDEX_WD];
  assign tag_in = addr_q[PC_WD-1 -: TAG_WD];
  assign word   = addr_q[2 +: WORD_WD];

  // Banks the read stage did not enable carry no meaningful data.
  assign bank_data[0] = bank_en_q[0] ? sram_rdata0 : '0;
  assign bank_data[1] = bank_en_q[1] ? sram_rdata1 : '0;
  assign bank_data[2] = bank_en_q[2] ? sram_rdata2 : '0;
  assign bank_data[3] = bank_en_q[3] ? sram_rdata3 : '0;

  assign hit0      = valid0_q[idx] && (tag0_q[idx] == tag_in);
  assign hit1      = valid1_q[idx] && (tag1_q[idx] == tag_in);
  assign hit_now   = hit0 || hit1;
  assign hit_way   = !hit0;
  assign hit_words = bank_data[{hit_way, idx[INDEX_WD-1]}];
  assign buf_words = line_buf_q;
  assign cur_hit   = first_q ? hit_now : hit_q;
  assign victim    = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

  assign cs_to_fs_valid = (state_q == LOOKUP) && cs_valid_q && cur_hit && !flush;
  assign cmp_allowin    = (state_q == LOOKUP) && !flush &&
                          (!cs_valid_q || (cs_to_fs_valid && fs_allowin));
  assign accept         = rs_to_cs_valid && cmp_allowin;
  assign cs_inst        = first_q ? hit_words[word] : hold_q;
  assign cs_pc          = addr_q;

  always_comb begin
    state_d     = state_q;
    cs_valid_d  = cs_valid_q;
    first_d     = first_q;
    hit_d       = hit_q;
    cancel_d    = cancel_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    bank_en_d   = bank_en_q;
    hold_d      = hold_q;
    line_buf_d  = line_buf_q;
    valid0_d    = valid0_q;
    valid1_d    = valid1_q;
    lru_d       = lru_q;
    tag0_d      = tag0_q;
    tag1_d      = tag1_q;
    sram_wen    = 4'b1111;
    sram_waddr  = '0;
    sram_wdata  = '0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;

    unique case (state_q)
      LOOKUP: begin
        if (cs_valid_q && first_q) begin
          first_d = 1'b0;
          if (hit_now) begin
            hit_d      = 1'b1;
            hold_d     = hit_words[word];
            lru_d[idx] = ~hit_way;
          end else begin
            state_d = MISS;
          end
        end
        if (cs_to_fs_valid && fs_allowin) begin
          cs_valid_d = 1'b0;
          hit_d      = 1'b0;
        end
        if (flush) begin
          cs_valid_d = 1'b0;
          first_d    = 1'b0;
          hit_d      = 1'b0;
          state_d    = LOOKUP;
        end
        // A new fetch overrides the retirement of the one just delivered.
        if (accept) begin
          addr_d     = rs_to_cs_bus[PC_WD+3:4];
          bank_en_d  = rs_to_cs_bus[3:0];
          cs_valid_d = 1'b1;
          first_d    = 1'b1;
          hit_d      = 1'b0;
        end
      end
      MISS: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {addr_q[PC_WD-1:OFFSET_WD], {OFFSET_WD{1'b0}}};
        if (flush) cancel_d = 1'b1;
        if (mem_rd_rdy) begin
          state_d = REFILL;
          beat_d  = 1'b0;
        end
      end
      REFILL: begin
        if (flush) cancel_d = 1'b1;
        if (mem_ret_valid) begin
          line_buf_d[beat_q] = mem_ret_data;
          beat_d             = ~beat_q;
          if (mem_ret_last) state_d = WRITE;
        end
      end
      WRITE: begin
        sram_wen[{victim, idx[INDEX_WD-1]}] = 1'b0;
        sram_waddr = idx[INDEX_WD-2:0];
        sram_wdata = line_buf_q;
        if (victim) begin
          tag1_d[idx]   = tag_in;
          valid1_d[idx] = 1'b1;
        end else begin
          tag0_d[idx]   = tag_in;
          valid0_d[idx] = 1'b1;
        end
        lru_d[idx] = ~victim;
        hold_d     = buf_words[word];
        state_d    = LOOKUP;
        first_d    = 1'b0;
        cancel_d   = 1'b0;
        // A cancelled fetch still fills the line but is never delivered.
        if (cancel_q || flush) begin
          cs_valid_d = 1'b0;
          hit_d      = 1'b0;
        end else begin
          hit_d      = 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= LOOKUP;
      cs_valid_q <= 1'b0;
      first_q    <= 1'b0;
      hit_q      <= 1'b0;
      cancel_q   <= 1'b0;
      beat_q     <= 1'b0;
      addr_q     <= '0;
      bank_en_q  <= '0;
      hold_q     <= '0;
      line_buf_q <= '0;
      valid0_q   <= '0;
      valid1_q   <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      cs_valid_q <= cs_valid_d;
      first_q    <= first_d;
      hit_q      <= hit_d;
      cancel_q   <= cancel_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      bank_en_q  <= bank_en_d;
      hold_q     <= hold_d;
      line_buf_q <= line_buf_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      lru_q      <= lru_d;
    end
  end

  // Tags are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    tag0_q <= tag0_d;
    tag1_q <= tag1_d;
  end

endmodule
